// File: rtl/jk_drv_pkg.sv
// Shared types and constants for the JK target driver.
// Excitation codes are packed as {J,K}.
package jk_drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } drv_state_e;

    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_TGL  = 2'b11;

endpackage

// File: rtl/jk_target_driver_excite.sv
// Per-bit excitation: picks HOLD, SET or RESET from current Q and target.
// TOGGLE is deliberately never produced.
module jk_excite
    import jk_drv_pkg::*;
(
    input  logic q,
    input  logic t,
    output logic j,
    output logic k
);

    logic [1:0] jk;

    always_comb begin
        jk = JK_HOLD;
        unique case ({q, t})
            2'b01:   jk = JK_SET;
            2'b10:   jk = JK_RST;
            default: jk = JK_HOLD;
        endcase
    end

    assign j = jk[1];
    assign k = jk[0];

endmodule

// File: rtl/jk_target_driver.sv
// Write-side driver for a JK register bank: capture target, excite, verify.
// JK_DRV_VERIFY_EN adds the CHECK state with bounded retries and err.
module jk_target_driver
    import jk_drv_pkg::*;
#(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned MAX_RETRY = 2
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] J,
    output logic [WIDTH-1:0] K,
    output logic             busy,
    output logic             done,
    output logic             err
);

    drv_state_e       state_d, state_q;
    logic [WIDTH-1:0] tgt_d, tgt_q;
    logic [WIDTH-1:0] j_raw, k_raw;
    logic             done_d, done_q;

`ifdef JK_DRV_VERIFY_EN
    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    logic [RW-1:0] retry_d, retry_q;
    logic          err_d, err_q;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_excite u_excite (
            .q (q_fb[i]),
            .t (tgt_q[i]),
            .j (j_raw[i]),
            .k (k_raw[i])
        );
    end

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
`ifdef JK_DRV_VERIFY_EN
        retry_d = retry_q;
        err_d   = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (tgt_valid) begin
                    tgt_d   = tgt_data;
                    state_d = DRIVE;
`ifdef JK_DRV_VERIFY_EN
                    retry_d = '0;
`endif
                end
            end
            DRIVE: begin
`ifdef JK_DRV_VERIFY_EN
                state_d = CHECK;
`else
                state_d = IDLE;
                done_d  = 1'b1;
`endif
            end
`ifdef JK_DRV_VERIFY_EN
            CHECK: begin
                if (q_fb == tgt_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (retry_q < RETRY_MAX) begin
                    retry_d = retry_q + RW'(1);
                    state_d = DRIVE;
                end else begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            tgt_q   <= '0;
            done_q  <= 1'b0;
`ifdef JK_DRV_VERIFY_EN
            retry_q <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            done_q  <= done_d;
`ifdef JK_DRV_VERIFY_EN
            retry_q <= retry_d;
            err_q   <= err_d;
`endif
        end
    end

    assign tgt_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign J         = (state_q == DRIVE) ? j_raw : '0;
    assign K         = (state_q == DRIVE) ? k_raw : '0;
    assign done      = done_q;
`ifdef JK_DRV_VERIFY_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

endmodule

// File: doc/jk_target_driver.md
# jk_target_driver

Sequential driver for a bank of WIDTH JK flip-flops. It accepts a target bit pattern over a valid/ready handshake, computes per-bit J/K excitation from the target and the bank's fed-back Q, and drives one excitation cycle. It then checks that the bank reached the target, retrying up to MAX_RETRY times, and reports `done` or `err`. It sits upstream of the JK register bank and is the write side of that bank.

## Interface
- WIDTH, 4: number of JK flip-flops driven.
- MAX_RETRY, 2: extra drive attempts after the first failed check; 0 means a single attempt.
- Clk  in  1  clock; all state changes on rising edge.
- Rst  in  1  reset; one clock, synchronous and active-high.
- tgt_valid  in  1  target pattern offered.
- tgt_ready  out  1  driver idle and able to accept; reset value 1.
- tgt_data  in  WIDTH  target pattern.
- q_fb  in  WIDTH  Q outputs of the driven JK bank.
- J  out  WIDTH  J excitation; reset value 0.
- K  out  WIDTH  K excitation; reset value 0.
- busy  out  1  high in every non-IDLE state; reset value 0.
- done  out  1  one-cycle pulse, bank matched target; reset value 0.
- err  out  1  one-cycle pulse, retries exhausted without match; reset value 0.

## Operation
- Excitation per bit i is a function of q = q_fb[i] and t = tgt_reg[i]:
  - q == t: HOLD (J=0, K=0).
  - q=0, t=1: SET (J=1, K=0).
  - q=1, t=0: RESET (J=0, K=1).
  - TOGGLE (J=1, K=1) is never generated.
- J/K are combinational from tgt_reg and q_fb, gated by state == DRIVE. They are 0 in all other states.
- FSM states are IDLE, DRIVE, CHECK.
  - IDLE: tgt_ready=1. On tgt_valid, capture tgt_data into tgt_reg, clear retry_cnt, and go to DRIVE.
  - DRIVE: lasts exactly one cycle, then goes to CHECK.
  - CHECK: J=K=0; compare q_fb with tgt_reg.
    - Equal: register done=1 and go to IDLE.
    - Unequal and retry_cnt < MAX_RETRY: increment retry_cnt and go to DRIVE.
    - Otherwise: register err=1 and go to IDLE.
- done and err are mutually exclusive.
- retry_cnt width is $clog2(MAX_RETRY+1), minimum 1 bit. It never wraps.
- Boundary rules:
  - tgt_valid while busy is ignored (tgt_ready=0) and no data is lost internally.
  - In the cycle done or err is high, the state is IDLE and a new target may be accepted in that same cycle.
  - Rst dominates every other input. It returns the FSM to IDLE, clears tgt_reg, retry_cnt, done and err, and suppresses any pending done/err.
  - A target equal to the current q_fb still runs DRIVE (all HOLD) and CHECK.

## Timing
- Cycle numbering: acceptance edge = e0.
- Cycle 1: DRIVE, J/K valid; the bank samples them at e1.
- Cycle 2: CHECK, q_fb compared.
- Cycle 3: done/err high, tgt_ready=1.
- Success latency is 3 cycles after acceptance. Each retry adds 2 cycles.
- Worst-case err latency is 3 + 2·MAX_RETRY cycles.
- Peak throughput is one target per 3 cycles.

## Configuration
- JK_DRV_VERIFY_EN defined:
  - CHECK state present; retry and err behaviour exactly as above.
- JK_DRV_VERIFY_EN undefined:
  - No CHECK state and no retry_cnt.
  - DRIVE goes directly to IDLE with done=1 registered, so done is high in cycle 2 after acceptance.
  - err is tied to 0; q_fb is used only for excitation; MAX_RETRY is ignored.

## Structure
- Package jk_drv_pkg holds:
  - the state enum typedef (IDLE, DRIVE, CHECK);
  - 2-bit excitation constants JK_HOLD=2'b00, JK_SET=2'b10, JK_RST=2'b01, JK_TGL=2'b11, encoded as {J,K}.
- Sub-module jk_excite: per-bit combinational mapping (q, t) → {J,K}, instantiated WIDTH times.
- The top level holds the FSM, tgt_reg, retry_cnt and the done/err registers.

## Test plan
The bench models the JK bank as Q ← J&~Q | ~K&Q on Clk. All scenarios use WIDTH=4, MAX_RETRY=2 and JK_DRV_VERIFY_EN defined unless stated otherwise.
- Reset: assert Rst 2 cycles → J=K=0, busy=0, done=err=0, tgt_ready=1.
- Normal drive: q=0110, target 1010 → cycle 1 J=1000, K=0100; cycle 3 done=1, q=1010, err=0.
- Stuck bit: bench forces q_fb[0]=0, target 0001 → three DRIVE cycles (1, 3, 5) with J=0001; err=1 in cycle 7; done never high.
- Already matching: q=0011, target 0011 → cycle 1 J=K=0000; done=1 in cycle 3.
- Reset and handshake: Rst in cycle 2 (CHECK) → IDLE next cycle, no done/err. Separately, tgt_valid held with new data 1111 during busy → not accepted until done cycle, then accepted in that cycle.
- Macro off (JK_DRV_VERIFY_EN undefined): target 1100 from q=0000 → J=1100 in cycle 1, done=1 in cycle 2, err stays 0.
